// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: ID-stage operand/destination info in, stall and EXE mux selects out.
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic [REG_ADDR_W-1:0] id_st_src;
  logic                  id_src1_vld;
  logic                  id_src2_vld;
  logic                  id_is_store;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_wb_en;
  logic                  id_mem_r_en;
  logic                  flush;
  logic                  stall;
  logic [1:0]            val1_sel;
  logic [1:0]            val2_sel;
  logic [1:0]            ST_val_sel;
  logic [CNT_W-1:0]      stall_cycles;
  modport master (
    output id_src1, id_src2, id_st_src, id_src1_vld, id_src2_vld, id_is_store,
    output id_dest, id_wb_en, id_mem_r_en, flush,
    input  stall, val1_sel, val2_sel, ST_val_sel, stall_cycles
  );
  modport slave (
    input  id_src1, id_src2, id_st_src, id_src1_vld, id_src2_vld, id_is_store,
    input  id_dest, id_wb_en, id_mem_r_en, flush,
    output stall, val1_sel, val2_sel, ST_val_sel, stall_cycles
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: tracks EX/MEM producers, registers EXE forwarding selects and stalls ID on hazards.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W      = 32
) (
  input logic                 clk,
  input logic                 rst,
  hazard_forward_unit_if.slave hz
);
  logic [REG_ADDR_W-1:0] ex_dest_q, ex_dest_d, mem_dest_q, mem_dest_d;
  logic                  ex_wb_q, ex_wb_d, ex_mr_q, ex_mr_d, mem_wb_q, mem_wb_d;
  logic [1:0]            val1_sel_q, val1_sel_d, val2_sel_q, val2_sel_d, st_sel_q, st_sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] src [3];
  logic [2:0]            used, hit_ex, hit_mem;
  logic [1:0]            sel [3];
  logic                  stall_c, bubble;
  always_comb begin
    src[0] = hz.id_src1;
    src[1] = hz.id_src2;
    src[2] = hz.id_st_src;
    used = {hz.id_is_store, hz.id_src2_vld, hz.id_src1_vld};
    stall_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hit_ex[i]  = used[i] && src[i] != '0 && ex_wb_q && ex_dest_q == src[i];
      hit_mem[i] = used[i] && src[i] != '0 && mem_wb_q && mem_dest_q == src[i];
      // Youngest producer wins; without forwarding every in-flight RAW waits for write-back.
      if (FORWARD_EN) begin
        stall_c = stall_c | (hit_ex[i] & ex_mr_q);
        sel[i]  = hit_ex[i] ? 2'b01 : hit_mem[i] ? 2'b10 : 2'b00;
      end else begin
        stall_c = stall_c | hit_ex[i] | hit_mem[i];
        sel[i]  = 2'b00;
      end
    end
    bubble     = stall_c | hz.flush;
    ex_dest_d  = bubble ? '0 : hz.id_dest;
    ex_wb_d    = bubble ? 1'b0 : hz.id_wb_en;
    ex_mr_d    = bubble ? 1'b0 : hz.id_mem_r_en;
    mem_dest_d = ex_dest_q;
    mem_wb_d   = ex_wb_q;
    val1_sel_d = bubble ? 2'b00 : sel[0];
    val2_sel_d = bubble ? 2'b00 : sel[1];
    st_sel_d   = bubble ? 2'b00 : sel[2];
    cnt_d      = (stall_c && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_dest_q  <= '0;
      ex_wb_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      mem_dest_q <= '0;
      mem_wb_q   <= 1'b0;
      val1_sel_q <= 2'b00;
      val2_sel_q <= 2'b00;
      st_sel_q   <= 2'b00;
      cnt_q      <= '0;
    end else begin
      ex_dest_q  <= ex_dest_d;
      ex_wb_q    <= ex_wb_d;
      ex_mr_q    <= ex_mr_d;
      mem_dest_q <= mem_dest_d;
      mem_wb_q   <= mem_wb_d;
      val1_sel_q <= val1_sel_d;
      val2_sel_q <= val2_sel_d;
      st_sel_q   <= st_sel_d;
      cnt_q      <= cnt_d;
    end
  end
  assign hz.stall        = stall_c;
  assign hz.val1_sel     = val1_sel_q;
  assign hz.val2_sel     = val2_sel_q;
  assign hz.ST_val_sel   = st_sel_q;
  assign hz.stall_cycles = cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed vectors against forwarding and non-forwarding instances.
module tb_hazard_forward_unit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_forward_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) f1 ();
  hazard_forward_unit_if #(.REG_ADDR_W(5), .CNT_W(2))  f0 ();
  hazard_forward_unit #(.REG_ADDR_W(5), .FORWARD_EN(1'b1), .CNT_W(32)) dut1 (.clk(clk), .rst(rst), .hz(f1));
  hazard_forward_unit #(.REG_ADDR_W(5), .FORWARD_EN(1'b0), .CNT_W(2))  dut0 (.clk(clk), .rst(rst), .hz(f0));
  typedef struct {
    logic [4:0] s1, s2, st, d;
    logic       v1, v2, ist, wb, mr, fl;
    logic       e_stall;
    logic [1:0] e1, e2, e3;
    int         e_cnt;
  } vec_t;
  vec_t tbl [22];
  function automatic vec_t mk(input logic [4:0] s1, input logic v1, input logic [4:0] s2, input logic v2,
                              input logic [4:0] st, input logic ist, input logic [4:0] d, input logic wb,
                              input logic mr, input logic fl, input logic es, input logic [1:0] e1,
                              input logic [1:0] e2, input logic [1:0] e3, input int ec);
    vec_t v;
    v.s1 = s1; v.v1 = v1; v.s2 = s2; v.v2 = v2; v.st = st; v.ist = ist; v.d = d; v.wb = wb;
    v.mr = mr; v.fl = fl; v.e_stall = es; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e_cnt = ec;
    return v;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input vec_t v);
    f1.id_src1 = v.s1; f1.id_src1_vld = v.v1; f1.id_src2 = v.s2; f1.id_src2_vld = v.v2;
    f1.id_st_src = v.st; f1.id_is_store = v.ist; f1.id_dest = v.d; f1.id_wb_en = v.wb;
    f1.id_mem_r_en = v.mr; f1.flush = v.fl;
    f0.id_src1 = v.s1; f0.id_src1_vld = v.v1; f0.id_src2 = v.s2; f0.id_src2_vld = v.v2;
    f0.id_st_src = v.st; f0.id_is_store = v.ist; f0.id_dest = v.d; f0.id_wb_en = v.wb;
    f0.id_mem_r_en = v.mr; f0.flush = v.fl;
  endtask
  // Present one ID instruction, check comb stall, clock once, check registered outputs.
  task automatic step(input string tag, input vec_t v, input bit fe);
    drive(v);
    #1;
    chk({tag, " stall"}, fe ? int'(f1.stall) : int'(f0.stall), int'(v.e_stall));
    @(posedge clk);
    #1;
    chk({tag, " val1_sel"}, fe ? int'(f1.val1_sel) : int'(f0.val1_sel), int'(v.e1));
    chk({tag, " val2_sel"}, fe ? int'(f1.val2_sel) : int'(f0.val2_sel), int'(v.e2));
    chk({tag, " ST_val_sel"}, fe ? int'(f1.ST_val_sel) : int'(f0.ST_val_sel), int'(v.e3));
    chk({tag, " stall_cycles"}, fe ? int'(f1.stall_cycles) : int'(f0.stall_cycles), v.e_cnt);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    //            s1 v1 s2 v2 st ist d  wb mr fl | stall e1 e2 e3 cnt
    tbl[0]  = mk( 1, 1, 2, 1, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk( 3, 1, 1, 1, 0, 0, 4, 1, 0, 0,  0, 1, 0, 0, 0);
    tbl[2]  = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[3]  = mk( 1, 1, 2, 1, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[4]  = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[5]  = mk( 1, 1, 3, 1, 0, 0, 5, 1, 0, 0,  0, 0, 2, 0, 0);
    tbl[6]  = mk( 0, 0, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[7]  = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[8]  = mk( 1, 1, 3, 0, 0, 0, 8, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[9]  = mk( 1, 1, 0, 0, 0, 0, 2, 1, 1, 0,  0, 0, 0, 0, 0);
    tbl[10] = mk( 2, 1, 2, 1, 0, 0, 6, 1, 0, 0,  1, 0, 0, 0, 1);
    tbl[11] = mk( 2, 1, 2, 1, 0, 0, 6, 1, 0, 0,  0, 2, 2, 0, 1);
    tbl[12] = mk( 1, 1, 1, 1, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0, 1);
    tbl[13] = mk( 1, 1, 0, 0, 7, 1, 0, 0, 0, 0,  0, 0, 0, 1, 1);
    tbl[14] = mk( 1, 1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1);
    tbl[15] = mk( 0, 1, 0, 1, 0, 0, 9, 1, 0, 0,  0, 0, 0, 0, 1);
    tbl[16] = mk( 1, 1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 1);
    tbl[17] = mk( 1, 1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 1);
    tbl[18] = mk( 3, 1, 3, 1, 0, 0,10, 1, 0, 0,  0, 1, 1, 0, 1);
    tbl[19] = mk( 1, 1, 0, 0, 0, 0,11, 1, 1, 0,  0, 0, 0, 0, 1);
    tbl[20] = mk(11, 1, 0, 0, 0, 0,12, 1, 0, 1,  1, 0, 0, 0, 2);
    tbl[21] = mk( 1, 1, 0, 0,11, 1, 0, 0, 0, 0,  0, 0, 0, 2, 2);
    do_reset();
    chk("reset stall", int'(f1.stall), 0);
    chk("reset val1_sel", int'(f1.val1_sel), 0);
    chk("reset val2_sel", int'(f1.val2_sel), 0);
    chk("reset ST_val_sel", int'(f1.ST_val_sel), 0);
    chk("reset stall_cycles", int'(f1.stall_cycles), 0);
    for (int i = 0; i < 22; i++) step($sformatf("fwd[%0d]", i), tbl[i], 1'b1);
    do_reset();
    chk("nofwd reset stall_cycles", int'(f0.stall_cycles), 0);
    step("nofwd add r3", mk(1,1,2,1,0,0,3,1,0,0, 0,0,0,0,0), 1'b0);
    step("nofwd use r3 ex", mk(3,1,1,1,0,0,4,1,0,0, 1,0,0,0,1), 1'b0);
    step("nofwd use r3 mem", mk(3,1,1,1,0,0,4,1,0,0, 1,0,0,0,2), 1'b0);
    step("nofwd use r3 go", mk(3,1,1,1,0,0,4,1,0,0, 0,0,0,0,2), 1'b0);
    step("nofwd use r4 ex", mk(4,1,0,0,0,0,5,1,0,0, 1,0,0,0,3), 1'b0);
    step("nofwd saturate", mk(4,1,0,0,0,0,5,1,0,0, 1,0,0,0,3), 1'b0);
    step("nofwd use r4 go", mk(4,1,0,0,0,0,5,1,0,0, 0,0,0,0,3), 1'b0);
    step("nofwd add r6", mk(1,1,0,0,0,0,6,1,0,0, 0,0,0,0,3), 1'b0);
    drive(mk(6,1,0,0,0,0,7,1,0,0, 0,0,0,0,0));
    #1;
    chk("rst mid-stall stall before", int'(f0.stall), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst mid-stall stall after", int'(f0.stall), 0);
    chk("rst mid-stall val1_sel", int'(f0.val1_sel), 0);
    chk("rst mid-stall stall_cycles", int'(f0.stall_cycles), 0);
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
